// File: rtl/lut_cfg_loader.sv
// Configuration sequencer for a fracturable dual-LUT slice: assembles a word stream into the
// slice config vector and pulses cfg_en once. Optional parity check enabled by CFG_PARITY_EN.
module lut_cfg_loader #(
  parameter  int unsigned INPUTS    = 4,
  parameter  int unsigned WORD_W    = 8,
  localparam int unsigned MEM_SIZE  = 2**INPUTS,
  localparam int unsigned CFG_W     = 2*MEM_SIZE+1,
  localparam int unsigned NUM_WORDS = (CFG_W+WORD_W-1)/WORD_W
) (
  input  logic              cclk,
  input  logic              crst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              cfg_en,
  output logic              busy,
  output logic              done
`ifdef CFG_PARITY_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned BUF_W = NUM_WORDS*WORD_W;
  localparam int unsigned SH_W  = $clog2(BUF_W);
  localparam int unsigned IDX_W = $clog2(NUM_WORDS+1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COMMIT = 3'd2,
    DONE   = 3'd3
`ifdef CFG_PARITY_EN
    ,
    CHECK  = 3'd4,
    ERROR  = 3'd5
`endif
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   word_idx, idx_next;
  logic [CFG_W-1:0]   buffer, buf_next;
  logic [SH_W-1:0]    word_shift;
`ifdef CFG_PARITY_EN
  logic               par_bit, par_next;
`endif

  assign word_shift = SH_W'(word_idx) * SH_W'(WORD_W);

  // State register
  always_ff @(posedge cclk) begin
    if (crst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_next = state;
    idx_next   = word_idx;
    buf_next   = buffer;
`ifdef CFG_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
          buf_next   = '0;
        end
      end
      LOAD: begin
        // abort beats a same-cycle transfer; that word is dropped
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
          buf_next   = '0;
        end else if (s_valid) begin
`ifdef CFG_PARITY_EN
          if (word_idx == IDX_W'(NUM_WORDS)) begin
            par_next   = s_data[0];
            state_next = CHECK;
          end else begin
            buf_next = buffer | CFG_W'(BUF_W'(s_data) << word_shift);
            idx_next = word_idx + IDX_W'(1);
          end
`else
          buf_next = buffer | CFG_W'(BUF_W'(s_data) << word_shift);
          idx_next = word_idx + IDX_W'(1);
          if (word_idx == IDX_W'(NUM_WORDS-1)) state_next = COMMIT;
`endif
        end
      end
      COMMIT: state_next = DONE;
`ifdef CFG_PARITY_EN
      CHECK: state_next = (par_bit == ^buffer) ? COMMIT : ERROR;
      ERROR: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
          buf_next   = '0;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge cclk) begin
    if (crst) begin
      word_idx <= '0;
      buffer   <= '0;
      cfg_out  <= '0;
      cfg_en   <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CFG_PARITY_EN
      par_bit  <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      word_idx <= idx_next;
      buffer   <= buf_next;
      cfg_en   <= (state_next == COMMIT);
      s_ready  <= (state_next == LOAD);
      done     <= (state_next == DONE);
      if (state_next == COMMIT) cfg_out <= buf_next;
`ifdef CFG_PARITY_EN
      par_bit  <= par_next;
      err      <= (state_next == ERROR);
      busy     <= (state_next == LOAD) || (state_next == COMMIT) || (state_next == CHECK);
`else
      busy     <= (state_next == LOAD) || (state_next == COMMIT);
`endif
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed self-checking bench for lut_cfg_loader; follows CFG_PARITY_EN when defined.
module tb_lut_cfg_loader;

  logic        cclk = 1'b0;
  logic        crst, start, abort, s_valid;
  logic [7:0]  s_data;
  logic        s_ready, cfg_en, busy, done;
  logic [32:0] cfg_out;
`ifdef CFG_PARITY_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int base;

  always #5 cclk = ~cclk;

  // Count cycles in which cfg_en was high
  always @(posedge cclk) if (cfg_en === 1'b1) en_cnt++;

  lut_cfg_loader dut (
    .cclk    (cclk),
    .crst    (crst),
    .start   (start),
    .abort   (abort),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .cfg_out (cfg_out),
    .cfg_en  (cfg_en),
    .busy    (busy),
    .done    (done)
`ifdef CFG_PARITY_EN
    ,
    .err     (err)
`endif
  );

  task automatic do_reset();
    crst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge cclk);
    crst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge cclk);
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Parity word (if built in) plus the CHECK cycle; returns inside COMMIT
  task automatic finish_load(input logic [32:0] cfg);
`ifdef CFG_PARITY_EN
    send({7'd0, ^cfg});
    @(negedge cclk);
`else
    if (cfg[0] === 1'bx) $display("[TB] unexpected X in expected config");
`endif
  endtask

  task automatic send_load(input logic [39:0] w);
    for (int i = 0; i < 5; i++) send(w[i*8 +: 8]);
    finish_load(w[32:0]);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({cfg_out, cfg_en, s_ready, busy, done} !== 37'd0) begin
      $display("FAIL reset_outputs: got %h required 0", {cfg_out, cfg_en, s_ready, busy, done});
      fails++;
    end
`ifdef CFG_PARITY_EN
    tests++;
    if (err !== 1'b0) begin $display("FAIL reset_err: got %b required 0", err); fails++; end
`endif
  endtask

  task automatic test_basic();
    do_start();
    tests++;
    if ({s_ready, busy} !== 2'b11) begin
      $display("FAIL basic_load_state: got s_ready,busy=%b required 11", {s_ready, busy}); fails++;
    end
    base = en_cnt;
    send_load(40'h01_44_33_22_11);
    tests++;
    if (cfg_en !== 1'b1) begin $display("FAIL basic_cfg_en: got %b required 1", cfg_en); fails++; end
    tests++;
    if (cfg_out !== 33'h1_4433_2211) begin
      $display("FAIL basic_cfg_out: got %h required 1_44332211", cfg_out); fails++;
    end
    tests++;
    if ({s_ready, done} !== 2'b00) begin
      $display("FAIL basic_commit_flags: got s_ready,done=%b required 00", {s_ready, done}); fails++;
    end
    @(negedge cclk);
    tests++;
    if ({cfg_en, done, busy} !== 3'b010) begin
      $display("FAIL basic_done: got cfg_en,done,busy=%b required 010", {cfg_en, done, busy}); fails++;
    end
    tests++;
    if (en_cnt - base !== 1) begin
      $display("FAIL basic_pulse_width: got %0d cycles required 1", en_cnt - base); fails++;
    end
  endtask

  task automatic test_gaps();
    int ready_low;
    ready_low = 0;
    do_start();
    send(8'h11);
    send(8'h22);
    for (int i = 0; i < 3; i++) begin
      if (s_ready !== 1'b1 || cfg_en !== 1'b0) ready_low++;
      @(negedge cclk);
    end
    tests++;
    if (ready_low !== 0) begin
      $display("FAIL gaps_ready: got %0d bad gap cycles required 0", ready_low); fails++;
    end
    send(8'h33);
    send(8'h44);
    send(8'h01);
    finish_load(33'h1_4433_2211);
    tests++;
    if ({cfg_en, cfg_out} !== {1'b1, 33'h1_4433_2211}) begin
      $display("FAIL gaps_commit: got cfg_en=%b cfg_out=%h required 1 / 1_44332211", cfg_en, cfg_out);
      fails++;
    end
    @(negedge cclk);
  endtask

  task automatic test_abort();
    do_start();
    tests++;
    if (done !== 1'b0) begin $display("FAIL abort_done_cleared: got %b required 0", done); fails++; end
    base = en_cnt;
    send(8'hAA);
    send(8'hBB);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'hCC;
    @(negedge cclk);
    abort = 1'b0; s_valid = 1'b0; s_data = '0;
    tests++;
    if ({busy, s_ready, done, cfg_en} !== 4'b0000) begin
      $display("FAIL abort_idle: got busy,s_ready,done,cfg_en=%b required 0000",
               {busy, s_ready, done, cfg_en}); fails++;
    end
    tests++;
    if (cfg_out !== 33'h1_4433_2211) begin
      $display("FAIL abort_cfg_hold: got %h required 1_44332211", cfg_out); fails++;
    end
    repeat (2) @(negedge cclk);
    tests++;
    if (en_cnt != base) begin
      $display("FAIL abort_no_en: got %0d pulses required 0", en_cnt - base); fails++;
    end
    do_start();
    send_load(40'hFF_FF_FF_FF_FF);
    tests++;
    if ({cfg_en, cfg_out} !== {1'b1, 33'h1_FFFF_FFFF}) begin
      $display("FAIL abort_reload: got cfg_en=%b cfg_out=%h required 1 / 1_FFFFFFFF", cfg_en, cfg_out);
      fails++;
    end
    @(negedge cclk);
  endtask

  task automatic test_reset_midload();
    do_start();
    base = en_cnt;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    crst = 1'b1;
    @(negedge cclk);
    crst = 1'b0;
    tests++;
    if ({cfg_out, cfg_en, s_ready, busy, done} !== 37'd0) begin
      $display("FAIL midreset_outputs: got %h required 0", {cfg_out, cfg_en, s_ready, busy, done});
      fails++;
    end
    tests++;
    if (en_cnt != base) begin
      $display("FAIL midreset_no_en: got %0d pulses required 0", en_cnt - base); fails++;
    end
    do_start();
    send_load(40'h00_DE_AD_BE_EF);
    tests++;
    if ({cfg_en, cfg_out} !== {1'b1, 33'h0_DEAD_BEEF}) begin
      $display("FAIL midreset_reload: got cfg_en=%b cfg_out=%h required 1 / 0_DEADBEEF", cfg_en, cfg_out);
      fails++;
    end
    @(negedge cclk);
  endtask

  task automatic test_ignored_start();
    start = 1'b1; abort = 1'b1;
    @(negedge cclk);
    start = 1'b0; abort = 1'b0;
    tests++;
    if ({busy, s_ready} !== 2'b11) begin
      $display("FAIL start_beats_abort: got busy,s_ready=%b required 11", {busy, s_ready}); fails++;
    end
    send(8'h78);
    send(8'h56);
    start = 1'b1;
    send(8'h34);
    start = 1'b0;
    send(8'h12);
    send(8'hFE);
    finish_load(33'h0_1234_5678);
    tests++;
    if ({cfg_en, cfg_out} !== {1'b1, 33'h0_1234_5678}) begin
      $display("FAIL trunc_cfg_out: got cfg_en=%b cfg_out=%h required 1 / 0_12345678", cfg_en, cfg_out);
      fails++;
    end
    start = 1'b1; abort = 1'b1;
    @(negedge cclk);
    start = 1'b0; abort = 1'b0;
    tests++;
    if ({done, busy, cfg_en} !== 3'b100) begin
      $display("FAIL commit_ignores_start: got done,busy,cfg_en=%b required 100", {done, busy, cfg_en});
      fails++;
    end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    do_start();
    base = en_cnt;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h01);
    send(8'h00);
    @(negedge cclk);
    tests++;
    if ({err, done, cfg_en, busy} !== 4'b1000) begin
      $display("FAIL parity_error: got err,done,cfg_en,busy=%b required 1000", {err, done, cfg_en, busy});
      fails++;
    end
    tests++;
    if (cfg_out !== 33'h0_1234_5678 || en_cnt != base) begin
      $display("FAIL parity_error_hold: got cfg_out=%h pulses=%0d required 0_12345678 / 0",
               cfg_out, en_cnt - base); fails++;
    end
    do_start();
    tests++;
    if (err !== 1'b0) begin $display("FAIL parity_err_clear: got %b required 0", err); fails++; end
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h01);
    send(8'h01);
    @(negedge cclk);
    tests++;
    if ({cfg_en, err, cfg_out} !== {2'b10, 33'h1_4433_2211}) begin
      $display("FAIL parity_commit: got cfg_en=%b err=%b cfg_out=%h required 1 0 1_44332211",
               cfg_en, err, cfg_out); fails++;
    end
    @(negedge cclk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_reset_midload();
    test_ignored_start();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Configuration sequencer for one fracturable dual-LUT slice.
- Accepts the slice bitstream as a valid/ready stream of narrow words and assembles the full {use_fracture, first_lut, second_lut} configuration vector.
- Presents that vector, then pulses the slice's config enable for exactly one cclk cycle.
- Sits between the fabric bitstream distributor and each LUT slice's cclk/cen/config_in pins.

Parameters:
- INPUTS, 4, inputs per LUT half.
- MEM_SIZE, 2**INPUTS, truth-table bits per LUT half.
- CFG_W, 2*MEM_SIZE+1, slice configuration width; MSB is the fracture bit.
- WORD_W, 8, stream word width.
- NUM_WORDS, (CFG_W+WORD_W-1)/WORD_W, data words per load (5 at defaults).

Ports:
- cclk  input  1  configuration clock.
- crst  input  1  synchronous active-high reset.
- start  input  1  begin a load; single-cycle pulse.
- abort  input  1  cancel the load in progress.
- s_data  input  WORD_W  bitstream word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a word this cycle.
- cfg_out  output  CFG_W  assembled configuration; drives slice config_in.
- cfg_en  output  1  one-cycle commit strobe; drives slice cen.
- busy  output  1  load in progress (LOAD or COMMIT state).
- done  output  1  last load committed successfully.
- err  output  1  parity failure; present only with CFG_PARITY_EN.

Behaviour:
- Reset (crst=1 at a cclk edge):
  - state=IDLE, word_idx=0, shift buffer=0.
  - cfg_out=0, cfg_en=0, s_ready=0, busy=0, done=0, err=0.
  - Reset wins over every other input and may occur mid-load. No cfg_en is emitted for a load that reset interrupts.
- States: IDLE, LOAD, COMMIT, DONE (plus CHECK and ERROR with the optional feature).
- IDLE / DONE:
  - start=1 -> LOAD. Clear word_idx and the buffer; clear done and err.
  - Without start, stay in the current state. done holds at 1 while in DONE.
- LOAD:
  - s_ready=1 and busy=1.
  - A word transfers on any cycle where s_valid && s_ready. It is written to buffer bits [word_idx*WORD_W +: WORD_W], LSB word first, and word_idx increments.
  - Buffer bits at or above CFG_W are discarded (7 padding bits at defaults).
  - When the transfer with word_idx==NUM_WORDS-1 occurs, go to COMMIT.
  - s_valid may drop between words; the loader waits indefinitely, with no timeout.
- COMMIT (one cycle):
  - cfg_out <= buffer[CFG_W-1:0]; cfg_en=1 for this single cycle. s_ready=0.
  - Next state is DONE.
  - cfg_out is registered and changes only on the cycle cfg_en rises. It is stable before and during the cfg_en cycle and holds until the next commit.
- Latency:
  - Last word accepted at edge N -> cfg_en=1 in cycle N+1 -> done=1 from cycle N+2.
  - Minimum load time is NUM_WORDS+1 cycles after start.
- start during LOAD or COMMIT is ignored.
- abort:
  - abort during LOAD -> IDLE. The buffer is cleared, cfg_out and cfg_en are untouched, and done stays 0.
  - abort in COMMIT is ignored; the commit completes.
  - abort in IDLE or DONE has no effect.
  - If abort and a word transfer occur in the same cycle, abort wins and the word is dropped. s_ready is 1 that cycle, so upstream must treat the word as consumed.
- If start and abort are both asserted in IDLE, start wins.
- cfg_en is never asserted outside COMMIT.

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - One extra word follows the NUM_WORDS data words. Only its bit 0 is used; it is the even-parity bit over cfg_out bits [CFG_W-1:0].
  - After the parity word transfers, the loader enters CHECK for one cycle and compares.
  - Match -> COMMIT as normal. Latency to cfg_en increases by 1 cycle relative to the undefined case.
  - Mismatch -> ERROR. err=1, done=0, no cfg_en, and cfg_out keeps its previous value.
  - ERROR exits only on start, which behaves as from IDLE, or on crst.
- Undefined: no err port, no CHECK or ERROR states, and exactly NUM_WORDS words per load.

Test Plan:
- Basic load:
  - Stimulus: reset, then start, then words 0x11,0x22,0x33,0x44,0x01 with s_valid held high.
  - Required response: cfg_out=33'h1_4433_2211, cfg_en high for exactly 1 cycle, 1 cycle after the 5th word; done=1 the following cycle.
- Backpressure and gaps:
  - Stimulus: same words, with s_valid low for 3 cycles between words 2 and 3.
  - Required response: identical cfg_out; cfg_en occurs 3 cycles later; s_ready=1 throughout LOAD.
- Abort mid-load:
  - Stimulus: commit 0x1_4433_2211, then start, words 0xAA,0xBB, then abort.
  - Required response: IDLE, cfg_en never asserted, cfg_out remains 0x1_4433_2211, done=0.
  - Follow-up: a subsequent full load of 0xFF x5 gives cfg_out=33'h1_FFFF_FFFF.
- Reset mid-load:
  - Stimulus: crst asserted after 3 words.
  - Required response: all outputs 0 on the next cycle; a new start with 5 words commits normally.
- Ignored start and truncation:
  - Stimulus: start pulses during LOAD and during COMMIT; word 5 = 0xFE.
  - Required response: starts have no effect; cfg_out[32]=0 and the upper padding bits are discarded.
- Parity (CFG_PARITY_EN defined):
  - Stimulus: words 0x11,0x22,0x33,0x44,0x01.
    - Parity word 0x00: mismatch (popcount is 11, odd) -> err=1, no cfg_en.
    - Parity word 0x01: commit, err=0.
